// File: rtl/prog_delay_mem.sv
// prog_delay_mem: runtime-programmable delay line built on a circular RAM.
//
// Every enabled cycle writes din at the write pointer. The output is read
// back from the tap located Deff-1 samples behind the write pointer, so the
// block behaves like a Deff-stage shift register clocked by en. A requested
// delay outside 1..DEPTH is clamped to the nearest legal value and flagged on
// delay_err.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (pointer, fill, outputs)
//   en          advance strobe; nothing moves on cycles with en=0
//   din         input sample, written on enabled edges
//   delay       requested delay in enabled samples (legal 1..DEPTH)
//   dout        delayed sample, registered
//   dout_valid  line holds at least Deff samples written under this delay
//   delay_err   registered flag, high while the requested delay is illegal
module prog_delay_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] delay,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          delay_err
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = AW + 1;

  // Clamp the requested delay into 1..DEPTH.
  function automatic logic [AW-1:0] eff_delay(input logic [AW-1:0] d);
    if (d == '0)                return AW'(1);
    else if (d > AW'(DEPTH))    return AW'(DEPTH);
    else                        return d;
  endfunction

  // Saturating fill counter increment, tops out at DEPTH.
  function automatic logic [AW-1:0] fill_inc(input logic [AW-1:0] f);
    if (f >= AW'(DEPTH)) return f;
    else                 return f + AW'(1);
  endfunction

  // Read tap (wp - (deff-1)) mod DEPTH; DEPTH need not be a power of two,
  // so the wrap is done explicitly rather than by bit truncation.
  function automatic logic [PW-1:0] tap_addr(input logic [PW-1:0] wp,
                                             input logic [AW-1:0] deff);
    logic [AW1-1:0] back;
    logic [AW1-1:0] base;
    back = {1'b0, deff} - AW1'(1);
    base = AW1'(wp);
    if (base >= back) return PW'(base - back);
    else              return PW'(base + AW1'(DEPTH) - back);
  endfunction

  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] fill_q,  fill_d;
  logic [AW-1:0] delay_q, delay_d;
  logic [DW-1:0] dout_q,  dout_d;
  logic          valid_q, valid_d;
  logic          err_q,   err_d;

  logic [AW-1:0] deff;
  logic          changed;
  logic [DW-1:0] rd_data;

  // Stage 0: clamp delay, detect a change, look up the tap, compute next state
  always_comb begin
    deff    = eff_delay(delay);
    changed = (deff != delay_q);
    rd_data = mem[tap_addr(wptr_q, deff)];

    wptr_d  = wptr_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    delay_d = deff;
    err_d   = (delay == '0) || (delay > AW'(DEPTH));

    if (en) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      // Deff=1 means the sample being written this edge is the output, and
      // it is not in the RAM yet, so bypass it directly.
      dout_d = (deff == AW'(1)) ? din : rd_data;
    end

    // A delay change restarts the fill so that valid only covers samples
    // written under the new delay.
    if (changed)  fill_d = en ? AW'(1) : '0;
    else if (en)  fill_d = fill_inc(fill_q);

    if (changed || en) valid_d = (fill_d >= deff);
  end

  // Stage 1: registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      fill_q  <= '0;
      delay_q <= AW'(1);
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      delay_q <= delay_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // RAM is never cleared; reset only suppresses the write on its edge.
  always_ff @(posedge clk) begin
    if (en && !rst) mem[wptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign delay_err  = err_q;

endmodule

// File: tb/tb_prog_delay_mem.sv
// tb_prog_delay_mem: table vectors, hand-written streams and randomized
// traffic against a sample-log reference model of prog_delay_mem.
module tb_prog_delay_mem;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] delay = AW'(1);
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          delay_err;

  prog_delay_mem #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .delay(delay),
    .dout(dout), .dout_valid(dout_valid), .delay_err(delay_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: a log of every sample written since the last reset.
  // The line output is simply the sample Deff-1 entries back in the log.
  int m_log[$];
  int m_cnt   = 0;
  int m_dq    = 1;
  int m_valid = 0;
  int m_dout  = 0;
  int m_known = 0;
  int m_err   = 0;

  function automatic int clamp(input int d);
    if (d == 0) return 1;
    if (d > DEPTH) return DEPTH;
    return d;
  endfunction

  task automatic model(input logic r, input logic e, input int d, input int dl);
    int deff;
    bit chg;
    deff  = clamp(dl);
    if (r) begin
      m_err = 0; m_valid = 0; m_dout = 0; m_known = 1;
      m_cnt = 0; m_dq = 1; m_log.delete();
      return;
    end
    m_err = (dl == 0 || dl > DEPTH) ? 1 : 0;
    chg   = (deff != m_dq);
    m_dq  = deff;
    if (e) begin
      m_log.push_back(d);
      if (m_log.size() > 40) void'(m_log.pop_front());
    end
    if (chg) m_cnt = e ? 1 : 0;
    else if (e && m_cnt < DEPTH) m_cnt++;
    if (chg || e) m_valid = (m_cnt >= deff) ? 1 : 0;
    if (e) begin
      if (m_log.size() >= deff) begin
        m_dout  = m_log[m_log.size() - deff];
        m_known = 1;
      end else m_known = 0;
    end
  endtask

  task automatic step(input logic r, input logic e, input int d, input int dl);
    rst = r; en = e; din = DW'(d); delay = AW'(dl);
    @(posedge clk);
    #1;
    model(r, e, d, dl);
  endtask

  // Reset, then stream n samples base+1.. at delay dl and check the
  // shift-register equivalence directly.
  task automatic stream(input string nm, input int dl, input int n, input int base);
    int deff;
    deff = clamp(dl);
    step(1'b1, 1'b1, 0, dl);
    for (int k = 1; k <= n; k++) begin
      step(1'b0, 1'b1, base + k, dl);
      chk({nm, "_valid"}, int'(dout_valid), (k >= deff) ? 1 : 0);
      chk({nm, "_err"}, int'(delay_err), (dl == 0 || dl > DEPTH) ? 1 : 0);
      if (k >= deff) chk({nm, "_dout"}, int'(dout), base + k - deff + 1);
    end
  endtask

  typedef struct {
    logic     r;
    logic     e;
    int       d;
    int       dl;
    int       ev;
    int       ee;
    bit       cd;
    int       ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic e, input int d, input int dl,
                              input int ev, input int ee, input bit cd, input int ed);
    vec_t v;
    v.r = r; v.e = e; v.d = d; v.dl = dl; v.ev = ev; v.ee = ee; v.cd = cd; v.ed = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    // Reset, delay=5 stream, then switch to 2, then illegal delays.
    add(1, 1, 0,  5, 0, 0, 1, 0);
    add(0, 1, 1,  5, 0, 0, 0, 0);
    add(0, 1, 2,  5, 0, 0, 0, 0);
    add(0, 1, 3,  5, 0, 0, 0, 0);
    add(0, 1, 4,  5, 0, 0, 0, 0);
    add(0, 1, 5,  5, 1, 0, 1, 1);
    add(0, 1, 6,  5, 1, 0, 1, 2);
    add(0, 1, 7,  5, 1, 0, 1, 3);
    add(0, 1, 8,  5, 1, 0, 1, 4);
    add(0, 1, 9,  2, 0, 0, 0, 0);
    add(0, 1, 10, 2, 1, 0, 1, 9);
    add(0, 1, 11, 2, 1, 0, 1, 10);
    add(0, 0, 55, 2, 1, 0, 1, 10);
    add(0, 1, 12, 0, 1, 1, 1, 12);
    add(0, 1, 13, 0, 1, 1, 1, 13);
    add(0, 0, 77, 0, 1, 1, 1, 13);
    add(0, 1, 14, 20, 0, 1, 0, 0);
    add(0, 1, 15, 20, 0, 1, 0, 0);
    add(0, 1, 16, 3, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].dl);
      chk($sformatf("tbl%0d_valid", i), int'(dout_valid), tbl[i].ev);
      chk($sformatf("tbl%0d_err", i), int'(delay_err), tbl[i].ee);
      if (tbl[i].cd) chk($sformatf("tbl%0d_dout", i), int'(dout), tbl[i].ed);
    end

    // Gated enable at delay=5: output follows enabled-edge order and holds.
    begin
      bit pat[14] = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1};
      int e_cnt;
      e_cnt = 0;
      step(1'b1, 1'b0, 0, 5);
      for (int i = 0; i < 14; i++) begin
        if (pat[i]) e_cnt++;
        step(1'b0, pat[i], pat[i] ? e_cnt : 200, 5);
        chk("gate_valid", int'(dout_valid), (e_cnt >= 5) ? 1 : 0);
        if (e_cnt >= 5) chk("gate_dout", int'(dout), e_cnt - 4);
      end
    end

    // Full depth across pointer wrap, Deff=1 via delay=0, clamp of delay=20.
    stream("d16", 16, 40, 0);
    stream("d0", 0, 4, 50);
    stream("d20", 20, 20, 100);

    // Reset in the middle of a valid delay=3 stream.
    stream("pre", 3, 6, 0);
    step(1'b1, 1'b1, 99, 3);
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_dout", int'(dout), 0);
    step(1'b0, 1'b1, 101, 3);
    chk("refill1_valid", int'(dout_valid), 0);
    step(1'b0, 1'b1, 102, 3);
    chk("refill2_valid", int'(dout_valid), 0);
    step(1'b0, 1'b1, 103, 3);
    chk("refill3_valid", int'(dout_valid), 1);
    chk("refill3_dout", int'(dout), 101);

    // Randomized traffic against the model.
    begin
      int dl;
      dl = 4;
      step(1'b1, 1'b0, 0, dl);
      for (int i = 0; i < 600; i++) begin
        logic r, e;
        if ($urandom_range(0, 19) == 0) dl = $urandom_range(0, 20);
        r = ($urandom_range(0, 49) == 0);
        e = ($urandom_range(0, 9) < 7);
        step(r, e, $urandom_range(0, 255), dl);
        chk("rnd_valid", int'(dout_valid), m_valid);
        chk("rnd_err", int'(delay_err), m_err);
        if (m_known != 0) chk("rnd_dout", int'(dout), m_dout);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
